uart_rx_apb_ctrl: RTL and testbench
===================================

Name: uart_rx_apb_ctrl

Overview:
- APB-slave control and configuration block for the UART receiver peripheral.
- Sequences APB setup/access phases.
- Holds the receiver configuration registers (bit period, data size) and exposes receiver status, error and data to the bus.
- Produces the one-cycle data_read handshake that tells the receiver its buffered byte has been consumed.

Parameters:
RESET_BIT_PERIOD, 14'd10, reset value of the bit_period register
RESET_DATA_SIZE, 4'd8, reset value of the data_size register

Ports:
clk  input  1  system clock, all logic on rising edge
n_rst  input  1  reset; synchronous, active-low
psel  input  1  APB slave select
penable  input  1  APB enable (access phase)
pwrite  input  1  1 = write, 0 = read
paddr  input  3  APB byte address
pwdata  input  8  APB write data
prdata  output  8  APB read data, valid during access phase
pslverr  output  1  APB error, valid during access phase
rx_data  input  8  received byte from receiver, right-justified
data_ready  input  1  receiver holds an unread byte
overrun_error  input  1  receiver overrun flag (level)
framing_error  input  1  receiver framing flag (level)
data_read  output  1  one-cycle pulse: RX_DATA consumed
bit_period  output  14  clocks per serial bit, to receiver timer
data_size  output  4  data bits per frame, to receiver

Behaviour:
- Reset: applied when n_rst=0 at a rising clk edge.
  - prdata=0, pslverr=0, data_read=0.
  - bit_period=RESET_BIT_PERIOD, data_size=RESET_DATA_SIZE.
  - FSM=IDLE.
  - Reset during any phase discards the pending transfer; no register is written.
- FSM states:
  - IDLE: psel=0.
  - SETUP: psel=1, penable=0. Address is decoded here.
  - ACCESS: psel=1, penable=1.
- Transitions:
  - IDLE->SETUP on psel & !penable.
  - SETUP->ACCESS next cycle when psel & penable.
  - ACCESS->SETUP if psel & !penable (back-to-back transfer); otherwise ACCESS->IDLE.
  - psel low in any state -> IDLE, no commit.
  - penable without psel is ignored.
- Zero wait states; every transfer is exactly 2 cycles.
- Read path: on the SETUP cycle edge, prdata and pslverr are registered so they are valid for the whole ACCESS cycle. Both return to 0 the cycle after ACCESS unless a new SETUP loads them.
- Register map (paddr):
  - 0 STATUS, RO: {7'b0, data_ready}.
  - 1 ERROR, RO: {6'b0, overrun_error, framing_error}.
  - 2 BIT_PERIOD_LO, RW: bit_period[7:0].
  - 3 BIT_PERIOD_HI, RW: bit_period[13:8]; bits 7:6 write-ignored, read 0.
  - 4 DATA_SIZE, RW: {4'b0, data_size}.
  - 6 RX_DATA, RO: rx_data masked to the low data_size bits, upper bits 0.
  - 5, 7: unmapped.
- Write commit: at the ACCESS cycle edge, using pwdata sampled in ACCESS.
  - DATA_SIZE accepts only 5, 7 or 8.
  - Any other DATA_SIZE value: pslverr=1 in ACCESS, register unchanged.
- pslverr=1 with prdata=0 and no state change for:
  - a write to RO addresses 0, 1, 6;
  - any access to unmapped 5 or 7.
- data_read:
  - Pulses high for exactly the one cycle following the ACCESS cycle of an RX_DATA read.
  - Pulses only if data_ready=1 when sampled at SETUP.
  - RX_DATA read with data_ready=0 returns masked rx_data, pslverr=0, no pulse.
- Config change mid-frame: bit_period and data_size update the cycle after commit. The receiver is responsible for when it resamples them.
- Status sampling: status and error reads reflect input values at the SETUP edge. A flag changing during ACCESS is not visible until the next read.

Test Plan:
1. Reset mid-transfer: drive n_rst=0 at the SETUP edge of a BIT_PERIOD_LO write of 0x55 -> bit_period=10, data_size=8, prdata=0, pslverr=0, FSM IDLE after the edge.
2. Bit-period config: write 0x34 to addr 2, then 0xFF to addr 3 -> bit_period=14'h3F34. Readback of addr 3 gives 0x3F, pslverr=0 both transfers.
3. Data-size legality: write 7 to addr 4 -> data_size=7, pslverr=0. Write 6 -> pslverr=1 in ACCESS, data_size stays 7.
4. RX data read: data_size=5, rx_data=0xFB, data_ready=1, read addr 6 -> prdata=0x1B in ACCESS, data_read=1 for exactly one cycle after ACCESS. Repeat with data_ready=0 -> same prdata, no pulse.
5. Error/status and illegal access: framing_error=1, overrun_error=1, read addr 1 -> 0x03. Write addr 0 -> pslverr=1. Read addr 7 -> prdata=0, pslverr=1.
6. Back-to-back and abort: two reads with psel held high, SETUP directly following ACCESS -> both return correct data, 4 cycles total. A SETUP followed by psel=0 -> no commit, FSM IDLE.

Source files
------------

// File: rtl/uart_rx_apb_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_apb_ctrl
//
// APB slave that configures and monitors the UART receiver.
//
// Ports:
//   clk, n_rst         system clock, synchronous active-low reset
//   psel, penable,     APB request: select, access phase, direction,
//   pwrite, paddr,     byte address and write data
//   pwdata
//   prdata, pslverr    APB response, registered at the setup edge so it is
//                      stable for the whole access cycle
//   rx_data,           receiver byte, unread flag and error levels
//   data_ready,
//   overrun_error,
//   framing_error
//   data_read          one-cycle pulse after an RX_DATA read of a ready byte
//   bit_period,        configuration driven to the receiver
//   data_size
//
// Register map: 0 STATUS(RO) 1 ERROR(RO) 2 BIT_PERIOD_LO 3 BIT_PERIOD_HI
//               4 DATA_SIZE (5/7/8 only) 6 RX_DATA(RO); 5 and 7 unmapped.
// ---------------------------------------------------------------------------
module uart_rx_apb_ctrl #(
  parameter logic [13:0] RESET_BIT_PERIOD = 14'd10,
  parameter logic [3:0]  RESET_DATA_SIZE  = 4'd8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [2:0]  paddr,
  input  logic [7:0]  pwdata,
  output logic [7:0]  prdata,
  output logic        pslverr,
  input  logic [7:0]  rx_data,
  input  logic        data_ready,
  input  logic        overrun_error,
  input  logic        framing_error,
  output logic        data_read,
  output logic [13:0] bit_period,
  output logic [3:0]  data_size
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_ERROR  = 3'd1;
  localparam logic [2:0] ADDR_BP_LO  = 3'd2;
  localparam logic [2:0] ADDR_BP_HI  = 3'd3;
  localparam logic [2:0] ADDR_DSIZE  = 3'd4;
  localparam logic [2:0] ADDR_RXDATA = 3'd6;

  state_e      state_q, state_d;
  logic [7:0]  prdata_q, prdata_d;
  logic        pslverr_q, pslverr_d;
  logic        data_read_q, data_read_d;
  logic        rx_rd_q, rx_rd_d;      // current transfer reads a ready byte
  logic        write_q, write_d;
  logic [2:0]  addr_q, addr_d;
  logic [13:0] bit_period_q, bit_period_d;
  logic [3:0]  data_size_q, data_size_d;

  logic        setup_phase;
  logic        access_phase;
  logic        load;                  // setup edge: capture response
  logic        commit;                // access edge of a properly set-up transfer
  logic        size_ok;
  logic [15:0] mask16;
  logic [7:0]  rd_data;
  logic        rd_err;

  assign setup_phase  = psel & ~penable;
  assign access_phase = psel & penable;
  assign load         = setup_phase;
  assign commit       = (state_q == SETUP) && access_phase;
  assign size_ok      = (pwdata == 8'd5) || (pwdata == 8'd7) || (pwdata == 8'd8);
  // Low data_size bits set; data_size never exceeds 8 so the byte slice suffices.
  assign mask16       = (16'd1 << data_size_q) - 16'd1;

  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (setup_phase) state_d = SETUP;
      SETUP:   if (access_phase) state_d = ACCESS;
               else if (setup_phase) state_d = SETUP;
               else state_d = IDLE;
      ACCESS:  if (setup_phase) state_d = SETUP;
               else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address decode of the request presented in the setup cycle. Writes and
  // errored accesses return zero data.
  always_comb begin
    rd_data = 8'h00;
    rd_err  = 1'b0;
    unique case (paddr)
      ADDR_STATUS: if (pwrite) rd_err = 1'b1;
                   else rd_data = {7'b0, data_ready};
      ADDR_ERROR:  if (pwrite) rd_err = 1'b1;
                   else rd_data = {6'b0, overrun_error, framing_error};
      ADDR_BP_LO:  if (!pwrite) rd_data = bit_period_q[7:0];
      ADDR_BP_HI:  if (!pwrite) rd_data = {2'b0, bit_period_q[13:8]};
      ADDR_DSIZE:  if (pwrite) rd_err = ~size_ok;
                   else rd_data = {4'b0, data_size_q};
      ADDR_RXDATA: if (pwrite) rd_err = 1'b1;
                   else rd_data = rx_data & mask16[7:0];
      default:     rd_err = 1'b1;
    endcase
  end

  always_comb begin
    prdata_d     = 8'h00;
    pslverr_d    = 1'b0;
    rx_rd_d      = 1'b0;
    write_d      = write_q;
    addr_d       = addr_q;
    data_read_d  = commit && rx_rd_q;
    bit_period_d = bit_period_q;
    data_size_d  = data_size_q;

    if (load) begin
      prdata_d  = rd_data;
      pslverr_d = rd_err;
      rx_rd_d   = !pwrite && (paddr == ADDR_RXDATA) && data_ready;
      write_d   = pwrite;
      addr_d    = paddr;
    end

    // Write data is taken from the access cycle; an errored transfer never
    // changes state.
    if (commit && write_q && !pslverr_q) begin
      unique case (addr_q)
        ADDR_BP_LO: bit_period_d[7:0]  = pwdata;
        ADDR_BP_HI: bit_period_d[13:8] = pwdata[5:0];
        ADDR_DSIZE: if (size_ok) data_size_d = pwdata[3:0];
        default:    ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      prdata_q     <= 8'h00;
      pslverr_q    <= 1'b0;
      data_read_q  <= 1'b0;
      rx_rd_q      <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= 3'd0;
      bit_period_q <= RESET_BIT_PERIOD;
      data_size_q  <= RESET_DATA_SIZE;
    end else begin
      state_q      <= state_d;
      prdata_q     <= prdata_d;
      pslverr_q    <= pslverr_d;
      data_read_q  <= data_read_d;
      rx_rd_q      <= rx_rd_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      bit_period_q <= bit_period_d;
      data_size_q  <= data_size_d;
    end
  end

  assign prdata     = prdata_q;
  assign pslverr    = pslverr_q;
  assign data_read  = data_read_q;
  assign bit_period = bit_period_q;
  assign data_size  = data_size_q;

endmodule

// File: tb/tb_uart_rx_apb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_apb_ctrl
//
// Directed bench for uart_rx_apb_ctrl. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle from the active edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_apb_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        psel, penable, pwrite;
  logic [2:0]  paddr;
  logic [7:0]  pwdata;
  logic [7:0]  prdata;
  logic        pslverr;
  logic [7:0]  rx_data;
  logic        data_ready, overrun_error, framing_error;
  logic        data_read;
  logic [13:0] bit_period;
  logic [3:0]  data_size;

  int checks   = 0;
  int failures = 0;

  uart_rx_apb_ctrl dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .prdata       (prdata),
    .pslverr      (pslverr),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .overrun_error(overrun_error),
    .framing_error(framing_error),
    .data_read    (data_read),
    .bit_period   (bit_period),
    .data_size    (data_size)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete 2-cycle transfer. Returns the access-cycle response, the
  // data_read level during access and in the following cycle, and prdata in
  // the following cycle.
  task automatic apb(input logic w, input logic [2:0] a, input logic [7:0] d,
                     output logic [7:0] rd, output logic err,
                     output logic dr_acc, output logic dr_after,
                     output logic [7:0] rd_after);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    rd = prdata; err = pslverr; dr_acc = data_read;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    dr_after = data_read; rd_after = prdata;
  endtask

  logic [7:0] rd, rd_after;
  logic       err, dr_acc, dr_after;

  initial begin
    n_rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 3'd0; pwdata = 8'h00; rx_data = 8'h00;
    data_ready = 1'b0; overrun_error = 1'b0; framing_error = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("rst_prdata", {8'h0, prdata}, 16'h0000);
    check("rst_pslverr", {15'h0, pslverr}, 16'h0000);
    check("rst_data_read", {15'h0, data_read}, 16'h0000);
    check("rst_bit_period", {2'b0, bit_period}, 16'd10);
    check("rst_data_size", {12'h0, data_size}, 16'd8);

    // Move bit_period off its reset value so the mid-transfer reset is visible.
    apb(1'b1, 3'd2, 8'h22, rd, err, dr_acc, dr_after, rd_after);
    check("pre_wr_err", {15'h0, err}, 16'h0000);
    check("pre_bit_period", {2'b0, bit_period}, 16'h0022);

    // 1. Reset at the setup edge of a BIT_PERIOD_LO write of 0x55.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd2; pwdata = 8'h55;
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1; penable = 1'b1;
    check("mid_rst_prdata", {8'h0, prdata}, 16'h0000);
    check("mid_rst_pslverr", {15'h0, pslverr}, 16'h0000);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    check("mid_rst_bit_period", {2'b0, bit_period}, 16'd10);
    check("mid_rst_data_size", {12'h0, data_size}, 16'd8);
    apb(1'b0, 3'd2, 8'h00, rd, err, dr_acc, dr_after, rd_after);
    check("mid_rst_rd_lo", {8'h0, rd}, 16'h000A);

    // 2. Bit-period configuration.
    apb(1'b1, 3'd2, 8'h34, rd, err, dr_acc, dr_after, rd_after);
    check("bp_lo_err", {15'h0, err}, 16'h0000);
    apb(1'b1, 3'd3, 8'hFF, rd, err, dr_acc, dr_after, rd_after);
    check("bp_hi_err", {15'h0, err}, 16'h0000);
    check("bp_value", {2'b0, bit_period}, 16'h3F34);
    apb(1'b0, 3'd3, 8'h00, rd, err, dr_acc, dr_after, rd_after);
    check("bp_hi_rd", {8'h0, rd}, 16'h003F);
    check("bp_hi_rd_err", {15'h0, err}, 16'h0000);
    check("prdata_after_access", {8'h0, rd_after}, 16'h0000);

    // 3. Data-size legality.
    apb(1'b1, 3'd4, 8'd7, rd, err, dr_acc, dr_after, rd_after);
    check("ds7_err", {15'h0, err}, 16'h0000);
    check("ds7_value", {12'h0, data_size}, 16'd7);
    apb(1'b1, 3'd4, 8'd6, rd, err, dr_acc, dr_after, rd_after);
    check("ds6_err", {15'h0, err}, 16'h0001);
    check("ds6_value", {12'h0, data_size}, 16'd7);
    apb(1'b0, 3'd4, 8'h00, rd, err, dr_acc, dr_after, rd_after);
    check("ds_rd", {8'h0, rd}, 16'h0007);

    // 4. RX data read, masked to 5 bits, with and without a ready byte.
    apb(1'b1, 3'd4, 8'd5, rd, err, dr_acc, dr_after, rd_after);
    check("ds5_value", {12'h0, data_size}, 16'd5);
    rx_data = 8'hFB; data_ready = 1'b1;
    apb(1'b0, 3'd0, 8'h00, rd, err, dr_acc, dr_after, rd_after);
    check("status_rd", {8'h0, rd}, 16'h0001);
    apb(1'b0, 3'd6, 8'h00, rd, err, dr_acc, dr_after, rd_after);
    check("rx_rd", {8'h0, rd}, 16'h001B);
    check("rx_rd_err", {15'h0, err}, 16'h0000);
    check("rx_dr_in_access", {15'h0, dr_acc}, 16'h0000);
    check("rx_dr_pulse", {15'h0, dr_after}, 16'h0001);
    @(negedge clk);
    check("rx_dr_one_cycle", {15'h0, data_read}, 16'h0000);
    data_ready = 1'b0;
    apb(1'b0, 3'd6, 8'h00, rd, err, dr_acc, dr_after, rd_after);
    check("rx_nr_rd", {8'h0, rd}, 16'h001B);
    check("rx_nr_err", {15'h0, err}, 16'h0000);
    check("rx_nr_no_pulse", {15'h0, dr_after}, 16'h0000);

    // 5. Error flags and illegal accesses.
    framing_error = 1'b1; overrun_error = 1'b1;
    apb(1'b0, 3'd1, 8'h00, rd, err, dr_acc, dr_after, rd_after);
    check("err_rd", {8'h0, rd}, 16'h0003);
    apb(1'b1, 3'd0, 8'hFF, rd, err, dr_acc, dr_after, rd_after);
    check("wr_ro_err", {15'h0, err}, 16'h0001);
    check("wr_ro_prdata", {8'h0, rd}, 16'h0000);
    apb(1'b0, 3'd7, 8'h00, rd, err, dr_acc, dr_after, rd_after);
    check("rd_unmapped_err", {15'h0, err}, 16'h0001);
    check("rd_unmapped_prdata", {8'h0, rd}, 16'h0000);
    apb(1'b1, 3'd5, 8'h12, rd, err, dr_acc, dr_after, rd_after);
    check("wr_unmapped_err", {15'h0, err}, 16'h0001);
    check("wr_unmapped_bp", {2'b0, bit_period}, 16'h3F34);

    // 6a. Back-to-back reads, psel held high: 4 cycles in total.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'd2;
    @(negedge clk);
    penable = 1'b1;
    check("b2b_rd0", {8'h0, prdata}, 16'h0034);
    check("b2b_err0", {15'h0, pslverr}, 16'h0000);
    @(negedge clk);
    penable = 1'b0; paddr = 3'd4;
    @(negedge clk);
    penable = 1'b1;
    check("b2b_rd1", {8'h0, prdata}, 16'h0005);
    check("b2b_err1", {15'h0, pslverr}, 16'h0000);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;

    // 6b. Setup then psel dropped: no commit. A stray penable is ignored.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd2; pwdata = 8'h99;
    @(negedge clk);
    psel = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    penable = 1'b0;
    check("abort_bp", {2'b0, bit_period}, 16'h3F34);
    apb(1'b0, 3'd2, 8'h00, rd, err, dr_acc, dr_after, rd_after);
    check("abort_rd_lo", {8'h0, rd}, 16'h0034);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
